// File: rtl/instr_fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// default address map and the PC increment.
package instr_fetch_sequencer_pkg;

    // RUN fetches normally, DRAIN_FAULT lets queued words leave after a bad
    // PC is seen, FAULT parks the sequencer until a redirect.
    typedef enum logic [1:0] {
        RUN         = 2'd0,
        DRAIN_FAULT = 2'd1,
        FAULT       = 2'd2
    } fetch_state_t;

    localparam logic [31:0] TEXT_BASE_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0040_0000;
    localparam logic [31:0] PC_STEP           = 32'd4;

endpackage

// File: rtl/instr_fetch_sequencer_if.sv
// Bus bundle between the fetch sequencer, the combinational program ROM and
// the decode stage.
//
// Handshake: Instr_Valid_o/Instr_Ready_i follow strict valid/ready rules. The
// master raises Instr_Valid_o only when Instr_o/Instr_PC_o hold a real word,
// keeps both stable until the cycle Instr_Valid_o & Instr_Ready_i is seen at a
// rising edge, and never makes Instr_Valid_o depend on Instr_Ready_i. A redirect
// is the only event that may withdraw a valid word without a transfer.
interface instr_fetch_sequencer_if #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] Rom_Address_o;
    logic [DATA_WIDTH-1:0] Rom_Instruction_i;
    logic [DATA_WIDTH-1:0] Instr_o;
    logic [31:0]           Instr_PC_o;
    logic                  Instr_Valid_o;
    logic                  Instr_Ready_i;

    // Sequencer side
    modport master (
        output Rom_Address_o,
        input  Rom_Instruction_i,
        output Instr_o,
        output Instr_PC_o,
        output Instr_Valid_o,
        input  Instr_Ready_i
    );

    // ROM / decode side
    modport slave (
        input  Rom_Address_o,
        output Rom_Instruction_i,
        input  Instr_o,
        input  Instr_PC_o,
        input  Instr_Valid_o,
        output Instr_Ready_i
    );
endinterface

// File: rtl/instr_fetch_sequencer_fetch_queue.sv
// Small synchronous FIFO holding {instruction, pc} pairs. Storage is fully
// registered so the head never sees the ROM combinationally.
module instr_fetch_sequencer_fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Storage, pointers and occupancy; flush empties the queue without
    // touching storage contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // The push gating upstream makes overflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_C);

endmodule

// File: rtl/instr_fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, maps it onto the program
// ROM, buffers fetched words and hands them to decode. Handles redirects,
// halt and out-of-range / misaligned PC faults.
module instr_fetch_sequencer
    import instr_fetch_sequencer_pkg::*;
#(
    parameter int          MEMORY_DEPTH = 64,
    parameter int          DATA_WIDTH   = 32,
    parameter logic [31:0] TEXT_BASE    = TEXT_BASE_DEFAULT,
    parameter logic [31:0] RESET_PC     = RESET_PC_DEFAULT,
    parameter int          QUEUE_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    instr_fetch_sequencer_if.master  bus,
    input  logic                     Redirect_i,
    input  logic [31:0]              Redirect_PC_i,
    input  logic                     Halt_i,
    output logic                     Fault_o,
    output logic [31:0]              Fetch_Count_o,
    output fetch_state_t             dbg_state
);
    localparam int          AW       = $clog2(MEMORY_DEPTH);
    localparam int          QW       = $clog2(QUEUE_DEPTH);
    localparam int          ENTRY_W  = DATA_WIDTH + 32;
    localparam logic [31:0] TEXT_END = TEXT_BASE + 32'(4 * MEMORY_DEPTH);

    fetch_state_t         state;
    fetch_state_t         state_next;
    logic [31:0]          fetch_pc;
    logic                 pc_ok;
    logic                 push;
    logic                 pop;
    logic [ENTRY_W-1:0]   q_head;
    logic [QW:0]          q_count;
    logic                 q_empty;
    logic                 q_full;

    // PC window check; the last ROM word is still legal.
    assign pc_ok = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= TEXT_BASE) && (fetch_pc < TEXT_END);

    // 32-bit byte offset turned into a word index, truncated to ROM width.
    assign bus.Rom_Address_o = AW'((fetch_pc - TEXT_BASE) >> 2);

    assign pop  = !q_empty && bus.Instr_Ready_i;
    assign push = (state == RUN) && !Halt_i && pc_ok && !Redirect_i && (!q_full || pop);

    instr_fetch_sequencer_fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_queue (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (Redirect_i),
        .din   ({bus.Rom_Instruction_i, fetch_pc}),
        .head  (q_head),
        .count (q_count),
        .empty (q_empty),
        .full  (q_full)
    );

    assign bus.Instr_o       = q_head[ENTRY_W-1:32];
    assign bus.Instr_PC_o    = q_head[31:0];
    assign bus.Instr_Valid_o = !q_empty;
    assign dbg_state         = state;

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a redirect always returns to RUN.
    always_comb begin
        state_next = state;
        if (Redirect_i) begin
            state_next = RUN;
        end else begin
            case (state)
                RUN:         if (!pc_ok && !Halt_i) state_next = DRAIN_FAULT;
                DRAIN_FAULT: if (q_count == '0)     state_next = FAULT;
                FAULT:       state_next = FAULT;
                default:     state_next = RUN;
            endcase
        end
    end

    // Fault flag follows FAULT entry and clears with the redirect that leaves it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Fault_o <= 1'b0;
        end else begin
            Fault_o <= (state_next == FAULT);
        end
    end

    // Fetch PC: redirect wins, otherwise advance one word per push.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= RESET_PC;
        end else if (Redirect_i) begin
            fetch_pc <= Redirect_PC_i;
        end else if (push) begin
            fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    // Accepted-instruction counter, wrapping at 2^32; a pop in a redirect
    // cycle still counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Fetch_Count_o <= '0;
        end else if (pop) begin
            Fetch_Count_o <= Fetch_Count_o + 32'd1;
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Self-checking bench for instr_fetch_sequencer with ROM[i] = i.
module tb_instr_fetch_sequencer;
    import instr_fetch_sequencer_pkg::*;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic         clk;
    logic         reset;
    logic         redirect;
    logic [31:0]  redirect_pc;
    logic         halt;
    logic         fault;
    logic [31:0]  fetch_count;
    fetch_state_t dbg_state;

    int checks;
    int passes;
    logic [63:0] exp_q[$];

    instr_fetch_sequencer_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

    instr_fetch_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .bus           (bus),
        .Redirect_i    (redirect),
        .Redirect_PC_i (redirect_pc),
        .Halt_i        (halt),
        .Fault_o       (fault),
        .Fetch_Count_o (fetch_count),
        .dbg_state     (dbg_state)
    );

    // ROM model: word i holds value i.
    assign bus.Rom_Instruction_i = 32'(bus.Rom_Address_o);

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] exp_item(input logic [31:0] pc);
        logic [31:0] w;
        w = (pc - BASE) >> 2;
        return {w, pc};
    endfunction

    task automatic push_range(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(exp_item(start + 32'(4 * i)));
    endtask

    // One clock cycle; accepted words are scored at the falling edge.
    task automatic tick();
        logic [63:0] exp_v;
        @(negedge clk);
        if (reset && bus.Instr_Valid_o && bus.Instr_Ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL accept: got pc=%h instr=%h, required no transfer", bus.Instr_PC_o, bus.Instr_o);
            end else begin
                exp_v = exp_q.pop_front();
                if ({bus.Instr_o, bus.Instr_PC_o} !== exp_v)
                    $display("FAIL accept: got instr/pc=%h required %h", {bus.Instr_o, bus.Instr_PC_o}, exp_v);
                else passes++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_accepts(input int n);
        bus.Instr_Ready_i = 1'b1;
        repeat (n) tick();
        bus.Instr_Ready_i = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        bus.Instr_Ready_i = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        bus.Instr_Ready_i = 1'b0;
        repeat (2) tick();
        checks++; if (bus.Instr_Valid_o !== 1'b0) $display("FAIL rst_valid: got %b required 0", bus.Instr_Valid_o); else passes++;
        checks++; if (bus.Instr_o !== 32'd0) $display("FAIL rst_instr: got %h required 0", bus.Instr_o); else passes++;
        checks++; if (bus.Instr_PC_o !== 32'd0) $display("FAIL rst_pc: got %h required 0", bus.Instr_PC_o); else passes++;
        checks++; if (fault !== 1'b0) $display("FAIL rst_fault: got %b required 0", fault); else passes++;
        checks++; if (fetch_count !== 32'd0) $display("FAIL rst_count: got %0d required 0", fetch_count); else passes++;
        checks++; if (bus.Rom_Address_o !== 6'd0) $display("FAIL rst_addr: got %0d required 0", bus.Rom_Address_o); else passes++;
        checks++; if (dbg_state !== RUN) $display("FAIL rst_state: got %0d required 0", dbg_state); else passes++;
    endtask

    task automatic test_stream();
        do_reset();
        bus.Instr_Ready_i = 1'b1;
        checks++; if (bus.Instr_Valid_o !== 1'b0) $display("FAIL stream_pre: got valid %b required 0", bus.Instr_Valid_o); else passes++;
        tick();
        checks++; if (bus.Instr_Valid_o !== 1'b1) $display("FAIL stream_first_valid: got %b required 1", bus.Instr_Valid_o); else passes++;
        push_range(BASE, 10);
        run_accepts(10);
        checks++; if (fetch_count !== 32'd10) $display("FAIL stream_count: got %0d required 10", fetch_count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL stream_left: got %0d pending required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            tick();
            checks++;
            if ({bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o} !== {1'b1, BASE, 32'd0})
                $display("FAIL bp_hold: got v=%b pc=%h instr=%h required 1/%h/0", bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o, BASE);
            else passes++;
        end
        checks++; if (bus.Rom_Address_o !== 6'd4) $display("FAIL bp_addr: got %0d required 4", bus.Rom_Address_o); else passes++;
        push_range(BASE, 8);
        run_accepts(8);
        checks++; if (fetch_count !== 32'd8) $display("FAIL bp_count: got %0d required 8", fetch_count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL bp_left: got %0d pending required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_redirect();
        do_reset();
        repeat (3) tick();
        checks++; if (bus.Instr_PC_o !== BASE) $display("FAIL rd_head: got %h required %h", bus.Instr_PC_o, BASE); else passes++;
        redirect = 1'b1;
        redirect_pc = 32'h0040_0020;
        bus.Instr_Ready_i = 1'b1;
        exp_q.push_back(exp_item(BASE));
        tick();
        redirect = 1'b0;
        checks++; if (bus.Instr_Valid_o !== 1'b0) $display("FAIL rd_gap: got valid %b required 0", bus.Instr_Valid_o); else passes++;
        checks++; if (fetch_count !== 32'd1) $display("FAIL rd_count1: got %0d required 1", fetch_count); else passes++;
        tick();
        checks++;
        if ({bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o} !== {1'b1, 32'h0040_0020, 32'd8})
            $display("FAIL rd_target: got v=%b pc=%h instr=%h required 1/00400020/8", bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o);
        else passes++;
        push_range(32'h0040_0020, 3);
        run_accepts(3);
        checks++; if (fetch_count !== 32'd4) $display("FAIL rd_count: got %0d required 4", fetch_count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL rd_left: got %0d pending required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_end_of_rom();
        do_reset();
        bus.Instr_Ready_i = 1'b1;
        tick();
        push_range(BASE, 64);
        run_accepts(64);
        checks++; if (fetch_count !== 32'd64) $display("FAIL eor_count: got %0d required 64", fetch_count); else passes++;
        checks++; if ({bus.Instr_Valid_o, fault} !== 2'b00) $display("FAIL eor_drain: got valid/fault %b required 00", {bus.Instr_Valid_o, fault}); else passes++;
        checks++; if (dbg_state !== DRAIN_FAULT) $display("FAIL eor_state_drain: got %0d required 1", dbg_state); else passes++;
        tick();
        checks++; if ({bus.Instr_Valid_o, fault} !== 2'b01) $display("FAIL eor_fault: got valid/fault %b required 01", {bus.Instr_Valid_o, fault}); else passes++;
        checks++; if (dbg_state !== FAULT) $display("FAIL eor_state_fault: got %0d required 2", dbg_state); else passes++;
        tick();
        checks++; if (fault !== 1'b1) $display("FAIL eor_sticky: got %b required 1", fault); else passes++;
        redirect = 1'b1;
        redirect_pc = BASE;
        tick();
        redirect = 1'b0;
        checks++; if ({bus.Instr_Valid_o, fault} !== 2'b00) $display("FAIL eor_clear: got valid/fault %b required 00", {bus.Instr_Valid_o, fault}); else passes++;
        tick();
        push_range(BASE, 2);
        run_accepts(2);
        checks++; if (fetch_count !== 32'd66) $display("FAIL eor_resume_count: got %0d required 66", fetch_count); else passes++;
        checks++; if (exp_q.size() != 0) $display("FAIL eor_left: got %0d pending required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_misaligned();
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h0040_0002;
        tick();
        redirect = 1'b0;
        checks++; if (fault !== 1'b0) $display("FAIL mis_fault0: got %b required 0", fault); else passes++;
        tick();
        checks++; if ({bus.Instr_Valid_o, fault} !== 2'b00) $display("FAIL mis_nopush: got valid/fault %b required 00", {bus.Instr_Valid_o, fault}); else passes++;
        tick();
        checks++; if (fault !== 1'b1) $display("FAIL mis_fault: got %b required 1", fault); else passes++;
        redirect = 1'b1;
        redirect_pc = 32'h0040_0010;
        tick();
        redirect = 1'b0;
        checks++; if (fault !== 1'b0) $display("FAIL mis_clear: got %b required 0", fault); else passes++;
        tick();
        checks++;
        if ({bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o} !== {1'b1, 32'h0040_0010, 32'd4})
            $display("FAIL mis_recover: got v=%b pc=%h instr=%h required 1/00400010/4", bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o);
        else passes++;
        exp_q.push_back(exp_item(32'h0040_0010));
        run_accepts(1);
        checks++; if (exp_q.size() != 0) $display("FAIL mis_left: got %0d pending required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_halt();
        do_reset();
        bus.Instr_Ready_i = 1'b1;
        tick();
        push_range(BASE, 4);
        run_accepts(4);
        bus.Instr_Ready_i = 1'b1;
        halt = 1'b1;
        exp_q.push_back(exp_item(32'h0040_0010));
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++; if (bus.Rom_Address_o !== 6'd5) $display("FAIL halt_pc_hold: got %0d required 5", bus.Rom_Address_o); else passes++;
        end
        checks++; if (bus.Instr_Valid_o !== 1'b0) $display("FAIL halt_drained: got %b required 0", bus.Instr_Valid_o); else passes++;
        halt = 1'b0;
        tick();
        checks++; if (bus.Instr_PC_o !== 32'h0040_0014) $display("FAIL halt_resume_pc: got %h required 00400014", bus.Instr_PC_o); else passes++;
        push_range(32'h0040_0014, 4);
        run_accepts(4);
        checks++; if (fetch_count !== 32'd9) $display("FAIL halt_count: got %0d required 9", fetch_count); else passes++;
        halt = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0040_0030;
        tick();
        redirect = 1'b0;
        repeat (2) tick();
        checks++; if ({bus.Instr_Valid_o, bus.Rom_Address_o} !== {1'b0, 6'd12}) $display("FAIL halt_redirect: got valid/addr %b/%0d required 0/12", bus.Instr_Valid_o, bus.Rom_Address_o); else passes++;
        halt = 1'b0;
        tick();
        checks++;
        if ({bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o} !== {1'b1, 32'h0040_0030, 32'd12})
            $display("FAIL halt_redirect_fetch: got v=%b pc=%h instr=%h required 1/00400030/12", bus.Instr_Valid_o, bus.Instr_PC_o, bus.Instr_o);
        else passes++;
        exp_q.push_back(exp_item(32'h0040_0030));
        run_accepts(1);
        checks++; if (exp_q.size() != 0) $display("FAIL halt_left: got %0d pending required 0", exp_q.size()); else passes++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.Instr_Ready_i = 1'b1;
        tick();
        push_range(BASE, 3);
        run_accepts(3);
        bus.Instr_Ready_i = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({bus.Instr_Valid_o, bus.Instr_o, bus.Instr_PC_o, fault, fetch_count} !== '0)
            $display("FAIL mid_reset: got v=%b instr=%h pc=%h fault=%b count=%0d required all 0",
                     bus.Instr_Valid_o, bus.Instr_o, bus.Instr_PC_o, fault, fetch_count);
        else passes++;
        checks++; if ({bus.Rom_Address_o, dbg_state} !== {6'd0, RUN}) $display("FAIL mid_reset_pc: got addr=%0d state=%0d required 0/0", bus.Rom_Address_o, dbg_state); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        halt = 1'b0;
        bus.Instr_Ready_i = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_end_of_rom();
        test_misaligned();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
